// File: rtl/hilo_pkg.sv
// Shared types and limits for the HI/LO iterative divider.
package hilo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DIV_MAX_WIDTH = 64;

endpackage

// File: rtl/hilo_divider_div_step.sv
// One radix-2 restoring iteration: shift {rem, quo} left, trial-subtract, keep or restore.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_dvsr,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;
  logic           w_neg;

  // Remainder stays below the divisor, so the shifted value and the trial
  // difference both fit in WIDTH+1 bits; the top bit of the difference is its sign.
  assign w_shift = {i_rem, i_quo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, i_dvsr};
  assign w_neg   = w_diff[WIDTH];

  assign o_rem = w_neg ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
  assign o_quo = {i_quo[WIDTH-2:0], ~w_neg};

endmodule

// File: rtl/hilo_divider.sv
// Iterative DIV/DIVU engine for the execute stage: WIDTH restoring iterations,
// sign fix-up, divide-by-zero result, and abort on pipeline flush.
module hilo_divider
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sign_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             cancel,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_t       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvsr;
  logic             r_qneg;
  logic             r_rneg;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_accept;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;
  logic [WIDTH-1:0] w_hi_fix;
  logic [WIDTH-1:0] w_lo_fix;

  assign w_accept = (r_state == IDLE) && start && !cancel;
  assign w_a_neg  = sign_mode && dividend[WIDTH-1];
  assign w_b_neg  = sign_mode && divisor[WIDTH-1];
  assign w_abs_a  = w_a_neg ? -dividend : dividend;
  assign w_abs_b  = w_b_neg ? -divisor  : divisor;

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem  (r_rem),
    .i_quo  (r_quo),
    .i_dvsr (r_dvsr),
    .o_rem  (w_rem_nxt),
    .o_quo  (w_quo_nxt)
  );

  // Sign fix-up is applied to the final iteration's result so that hi/lo are
  // already visible in the DONE cycle alongside valid.
  assign w_lo_fix = r_qneg ? -w_quo_nxt : w_quo_nxt;
  assign w_hi_fix = r_rneg ? -w_rem_nxt : w_rem_nxt;

  // NOTE: every register here is written with <= so all state advances together
  // on the clock edge; a blocking = would let later statements see new values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvsr  <= '0;
      r_qneg  <= 1'b0;
      r_rneg  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else if (cancel) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              r_hi    <= dividend;
              r_lo    <= '1;
              r_state <= DONE;
            end else begin
              r_rem   <= '0;
              r_quo   <= w_abs_a;
              r_dvsr  <= w_abs_b;
              r_qneg  <= w_a_neg ^ w_b_neg;
              r_rneg  <= w_a_neg;
              r_cnt   <= CW'(WIDTH);
              r_state <= DIV;
            end
          end
        end
        DIV: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) begin
            r_hi    <= w_hi_fix;
            r_lo    <= w_lo_fix;
            r_state <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy  = w_accept || (r_state == DIV);
  assign valid = (r_state == DONE);
  assign hi    = r_hi;
  assign lo    = r_lo;

endmodule

// File: tb/tb_hilo_divider.sv
// Self-checking bench for hilo_divider at WIDTH=32 and WIDTH=8 against an
// arithmetic reference model built on 64-bit integer division.
module tb_hilo_divider;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic        start32, sign32, cancel32, busy32, valid32;
  logic [31:0] a32, b32, hi32, lo32;
  logic        start8, sign8, cancel8, busy8, valid8;
  logic [7:0]  a8, b8, hi8, lo8;

  int n_vec = 0;
  int n_err = 0;

  hilo_divider #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .start(start32), .sign_mode(sign32),
    .dividend(a32), .divisor(b32), .cancel(cancel32),
    .busy(busy32), .valid(valid32), .hi(hi32), .lo(lo32)
  );

  hilo_divider #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .sign_mode(sign8),
    .dividend(a8), .divisor(b8), .cancel(cancel8),
    .busy(busy8), .valid(valid8), .hi(hi8), .lo(lo8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: truncating division on sign- or zero-extended 64-bit values.
  function automatic void model(input logic [63:0] a_in, input logic [63:0] b_in,
                                input bit s, input int w,
                                output logic [63:0] q, output logic [63:0] r);
    logic [63:0] mask;
    logic [63:0] a;
    logic [63:0] b;
    longint sa, sb;
    mask = (64'd1 << w) - 64'd1;
    a = a_in & mask;
    b = b_in & mask;
    if (b == 64'd0) begin
      q = mask;
      r = a;
      return;
    end
    sa = longint'(a);
    sb = longint'(b);
    if (s && a[w-1]) sa = sa - (longint'(1) << w);
    if (s && b[w-1]) sb = sb - (longint'(1) << w);
    q = 64'(sa / sb) & mask;
    r = 64'(sa % sb) & mask;
  endfunction

  task automatic drive(input int w, input bit st, input logic [63:0] a, input logic [63:0] b,
                       input bit s);
    if (w == 32) begin
      start32 = st; sign32 = s; a32 = a[31:0]; b32 = b[31:0];
    end else begin
      start8 = st; sign8 = s; a8 = a[7:0]; b8 = b[7:0];
    end
  endtask

  // Launch one divide, follow it to valid, and compare latency, busy profile and results.
  // inject > 0 presents an unrelated start in that cycle after acceptance.
  task automatic run_op(input int w, input logic [63:0] a, input logic [63:0] b,
                        input bit s, input string tag, input int inject);
    logic [63:0] eq, er, mask, obs_hi, obs_lo;
    int  lat, exp_lat;
    bit  busy_ok, bsy, vld;
    mask = (64'd1 << w) - 64'd1;
    model(a, b, s, w, eq, er);
    exp_lat = ((b & mask) == 64'd0) ? 1 : w + 1;
    busy_ok = 1'b1;
    lat = -1;
    @(negedge clk);
    drive(w, 1'b1, a, b, s);
    #1;
    bsy = (w == 32) ? busy32 : busy8;
    if (bsy !== 1'b1) busy_ok = 1'b0;
    for (int k = 1; k <= w + 4; k++) begin
      @(negedge clk);
      if (k == 1) drive(w, 1'b0, a, b, s);
      if (inject > 0 && k == inject) drive(w, 1'b1, ~a, b + 64'd1, ~s);
      if (inject > 0 && k == inject + 1) drive(w, 1'b0, a, b, s);
      #1;
      bsy = (w == 32) ? busy32 : busy8;
      vld = (w == 32) ? valid32 : valid8;
      if (bsy !== (k < exp_lat)) busy_ok = 1'b0;
      if (vld === 1'b1) begin
        lat = k;
        break;
      end
    end
    drive(w, 1'b0, a, b, s);
    obs_hi = (w == 32) ? 64'(hi32) : 64'(hi8);
    obs_lo = (w == 32) ? 64'(lo32) : 64'(lo8);
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " lo"}, obs_lo, eq);
    check({tag, " hi"}, obs_hi, er);
    check({tag, " busy"}, 64'(busy_ok), 64'd1);
    @(negedge clk);
    vld = (w == 32) ? valid32 : valid8;
    check({tag, " valid_pulse"}, 64'(vld), 64'd0);
  endtask

  // Launch a 32-bit divide and stop at the negedge of cycle t+10 (still in DIV).
  task automatic launch32_to_t10(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    drive(32, 1'b1, 64'(a), 64'(b), 1'b0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) start32 = 1'b0;
    end
  endtask

  initial begin
    logic [63:0] ra, rb;
    bit          rs, saw_valid;

    rst = 1'b1;
    drive(32, 1'b0, 64'd0, 64'd0, 1'b0);
    drive(8, 1'b0, 64'd0, 64'd0, 1'b0);
    cancel32 = 1'b0;
    cancel8  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset hi32", 64'(hi32), 64'd0);
    check("reset lo32", 64'(lo32), 64'd0);
    check("reset valid32", 64'(valid32), 64'd0);
    check("reset busy32", 64'(busy32), 64'd0);
    check("reset hi8", 64'(hi8), 64'd0);
    rst = 1'b0;

    // Directed cases.
    run_op(32, 64'd100, 64'd7, 1'b0, "u32 100/7", 0);
    run_op(32, 64'hFFFF_FFF9, 64'd2, 1'b1, "s32 -7/2", 0);
    run_op(32, 64'hFFFF_FFFF, 64'd2, 1'b0, "u32 max/2", 0);
    run_op(32, 64'h8000_0000, 64'hFFFF_FFFF, 1'b1, "s32 min/-1", 0);
    run_op(32, 64'd7, 64'hFFFF_FFFE, 1'b1, "s32 7/-2", 0);
    run_op(32, 64'd5, 64'd0, 1'b0, "u32 5/0", 0);
    run_op(32, 64'hFFFF_FFFB, 64'd0, 1'b1, "s32 -5/0", 0);
    run_op(8, 64'd200, 64'd9, 1'b0, "u8 200/9 with ignored start", 3);
    run_op(8, 64'h80, 64'hFF, 1'b1, "s8 min/-1", 0);

    // Cancel mid-operation after a known 2/14 result.
    run_op(32, 64'd100, 64'd7, 1'b0, "u32 100/7 pre-cancel", 0);
    launch32_to_t10(32'd1000, 32'd3);
    cancel32 = 1'b1;
    @(negedge clk);
    cancel32 = 1'b0;
    #1;
    check("cancel busy", 64'(busy32), 64'd0);
    check("cancel valid", 64'(valid32), 64'd0);
    saw_valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (valid32 === 1'b1) saw_valid = 1'b1;
    end
    check("cancel no_valid", 64'(saw_valid), 64'd0);
    check("cancel hi held", 64'(hi32), 64'd2);
    check("cancel lo held", 64'(lo32), 64'd14);

    // Cancel wins over a simultaneous start.
    @(negedge clk);
    drive(32, 1'b1, 64'd9, 64'd3, 1'b0);
    cancel32 = 1'b1;
    #1;
    check("cancel+start busy", 64'(busy32), 64'd0);
    @(negedge clk);
    drive(32, 1'b0, 64'd9, 64'd3, 1'b0);
    cancel32 = 1'b0;
    #1;
    check("cancel+start idle busy", 64'(busy32), 64'd0);
    check("cancel+start idle valid", 64'(valid32), 64'd0);

    // Reset mid-operation clears results.
    launch32_to_t10(32'd1000, 32'd3);
    rst = 1'b1;
    @(negedge clk);
    check("midrst hi", 64'(hi32), 64'd0);
    check("midrst lo", 64'(lo32), 64'd0);
    check("midrst valid", 64'(valid32), 64'd0);
    check("midrst busy", 64'(busy32), 64'd0);
    rst = 1'b0;

    // Randomised operands, with small and zero divisors mixed in.
    for (int i = 0; i < 14; i++) begin
      ra = 64'($urandom);
      case ($urandom_range(0, 7))
        0:       rb = 64'd0;
        1, 2:    rb = 64'($urandom_range(1, 17));
        3:       rb = 64'hFFFF_FFFF - 64'($urandom_range(0, 5));
        default: rb = 64'($urandom);
      endcase
      rs = 1'($urandom);
      run_op(32, ra, rb, rs, $sformatf("rand32 #%0d", i), 0);
    end
    for (int i = 0; i < 10; i++) begin
      ra = 64'($urandom_range(0, 255));
      rb = ($urandom_range(0, 7) == 0) ? 64'd0 : 64'($urandom_range(0, 255));
      rs = 1'($urandom);
      run_op(8, ra, rb, rs, $sformatf("rand8 #%0d", i), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
